// File: rtl/poly_mult_mac.sv
// Streaming NTT-based polynomial multiply/accumulate over Z_Q[x]/(x^N +/- 1).
// Generates its twiddle tables in INIT, then loops LOAD -> NTT -> MAC -> (LOAD | INTT -> OUT).
module poly_mult_mac #(
    parameter int Q       = 17,
    parameter int N       = 8,
    parameter int LOGQ    = 5,
    parameter int LOGN    = 3,
    parameter int PSI     = 3,
    parameter int PSI_INV = 6,
    parameter int N_INV   = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [LOGQ-1:0] poly_in0,
    input  logic [LOGQ-1:0] poly_in1,
    input  logic            acc,
    input  logic            cyclic,
    output logic            in_ready,
    output logic            out_valid,
    output logic [LOGQ-1:0] poly_out,
    input  logic            out_ready,
    output logic            busy
);

    localparam int              SW          = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam logic [SW-1:0]   LAST_STAGE  = SW'(LOGN - 1);
    localparam logic [LOGN-1:0] CNT_MAX     = LOGN'(N - 1);
    localparam logic [LOGQ-1:0] ONE         = LOGQ'(1);
    localparam logic [LOGQ-1:0] Q_L         = LOGQ'(Q);
    localparam logic [LOGQ:0]   Q_W         = (LOGQ + 1)'(Q);
    localparam logic [2*LOGQ-1:0] Q_P       = (2 * LOGQ)'(Q);
    localparam logic [LOGQ-1:0] NINV_L      = LOGQ'(N_INV);
    localparam logic [LOGQ-1:0] PSI_L       = LOGQ'(PSI);
    localparam logic [LOGQ-1:0] PSI_INV_L   = LOGQ'(PSI_INV);
    localparam logic [LOGQ-1:0] OMEGA_L     = LOGQ'((PSI * PSI) % Q);
    localparam logic [LOGQ-1:0] OMEGA_INV_L = LOGQ'((PSI_INV * PSI_INV) % Q);

    typedef enum logic [2:0] {S_INIT, S_LOAD, S_NTT, S_MAC, S_INTT, S_OUT} state_t;

    function automatic logic [LOGQ-1:0] mulmod(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b);
        logic [2*LOGQ-1:0] p;
        logic [2*LOGQ-1:0] r;
        p = a * b;
        r = p % Q_P;
        return r[LOGQ-1:0];
    endfunction

    function automatic logic [LOGQ-1:0] addmod(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b);
        logic [LOGQ:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_W) s = s - Q_W;
        return s[LOGQ-1:0];
    endfunction

    function automatic logic [LOGQ-1:0] submod(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b);
        return (a >= b) ? (a - b) : (a + (Q_L - b));
    endfunction

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
        return r;
    endfunction

    state_t          state, state_n;
    logic [LOGN-1:0] cnt;
    logic [SW-1:0]   stage;
    logic            acc_first, acc_q, cyc_q;

    logic [LOGQ-1:0] a_mem [N];
    logic [LOGQ-1:0] b_mem [N];
    logic [LOGQ-1:0] c_mem [N];
    logic [LOGQ-1:0] w_tab [N];
    logic [LOGQ-1:0] iw_tab [N];
    logic [LOGQ-1:0] phi_tab [N];
    logic [LOGQ-1:0] iphi_tab [N];

    logic            in_fire, out_fire, cnt_last, stage_last, bf_en, mode_now;
    logic [LOGN-1:0] prev, half_bit, hi_idx, tw_idx, rev_idx, out_idx;
    logic [2*LOGN-1:0] tw_wide;
    logic [LOGQ-1:0] twist, a_v, b_v, c_v, mac_sum, out_coef;

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign cnt_last   = (cnt == CNT_MAX);
    assign stage_last = (stage == LAST_STAGE);
    assign prev       = cnt - 1'b1;
    assign rev_idx    = bitrev(cnt);

    // Butterfly pairs (cnt, cnt | 2^stage); twiddle exponent is (cnt mod 2^stage) * N / 2^(stage+1).
    assign half_bit = LOGN'(1) << stage;
    assign hi_idx   = cnt | half_bit;
    assign bf_en    = ~cnt[stage];
    assign tw_wide  = {{LOGN{1'b0}}, cnt} << (LAST_STAGE - stage);
    assign tw_idx   = tw_wide[LOGN-1:0];
    assign a_v      = mulmod(a_mem[hi_idx], w_tab[tw_idx]);
    assign b_v      = mulmod(b_mem[hi_idx], w_tab[tw_idx]);
    assign c_v      = mulmod(c_mem[hi_idx], iw_tab[tw_idx]);

    // The mode of the beat being accepted is live on beat 0, latched afterwards.
    assign mode_now = (cnt == '0) ? cyclic : cyc_q;
    assign twist    = mode_now ? ONE : phi_tab[cnt];
    assign mac_sum  = addmod(acc_first ? '0 : c_mem[rev_idx], mulmod(a_mem[cnt], b_mem[cnt]));

    assign out_idx  = (state != S_OUT) ? '0 : (out_fire ? cnt + 1'b1 : cnt);
    assign out_coef = mulmod(c_mem[out_idx], cyc_q ? NINV_L : iphi_tab[out_idx]);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            S_INIT:  if (cnt_last) state_n = S_LOAD;
            S_LOAD:  if (in_fire && cnt_last) state_n = S_NTT;
            S_NTT:   if (cnt_last && stage_last) state_n = S_MAC;
            S_MAC:   if (cnt_last) state_n = acc_q ? S_LOAD : S_INTT;
            S_INTT:  if (cnt_last && stage_last) state_n = S_OUT;
            S_OUT:   if (out_fire && cnt_last) state_n = S_LOAD;
            default: state_n = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_INIT;
            cnt       <= '0;
            stage     <= '0;
            acc_first <= 1'b1;
            acc_q     <= 1'b0;
            cyc_q     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            poly_out  <= '0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == S_LOAD);
            out_valid <= (state_n == S_OUT);
            busy      <= (state_n != S_LOAD);
            poly_out  <= (state_n == S_OUT) ? out_coef : '0;
            case (state)
                S_INIT, S_MAC: cnt <= cnt + 1'b1;
                S_LOAD: if (in_fire) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) begin
                        acc_q <= acc;
                        cyc_q <= cyclic;
                    end
                end
                S_NTT, S_INTT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt_last) stage <= stage_last ? '0 : stage + 1'b1;
                end
                S_OUT:   if (out_fire) cnt <= cnt + 1'b1;
                default: ;
            endcase
            if (state == S_MAC && cnt_last) acc_first <= 1'b0;
            if (state == S_OUT && out_fire && cnt_last) acc_first <= 1'b1;
        end
    end

    // NOTE: the coefficient and twiddle memories carry no reset; INIT and LOAD rewrite them before use.
    always_ff @(posedge clk) begin
        case (state)
            S_INIT: if (cnt == '0) begin
                w_tab[0]    <= ONE;
                iw_tab[0]   <= ONE;
                phi_tab[0]  <= ONE;
                iphi_tab[0] <= NINV_L;
            end else begin
                w_tab[cnt]    <= mulmod(w_tab[prev], OMEGA_L);
                iw_tab[cnt]   <= mulmod(iw_tab[prev], OMEGA_INV_L);
                phi_tab[cnt]  <= mulmod(phi_tab[prev], PSI_L);
                iphi_tab[cnt] <= mulmod(iphi_tab[prev], PSI_INV_L);
            end
            S_LOAD: if (in_fire) begin
                a_mem[rev_idx] <= mulmod(poly_in0, twist);
                b_mem[rev_idx] <= mulmod(poly_in1, twist);
            end
            S_NTT: if (bf_en) begin
                a_mem[cnt]    <= addmod(a_mem[cnt], a_v);
                a_mem[hi_idx] <= submod(a_mem[cnt], a_v);
                b_mem[cnt]    <= addmod(b_mem[cnt], b_v);
                b_mem[hi_idx] <= submod(b_mem[cnt], b_v);
            end
            S_MAC: c_mem[rev_idx] <= mac_sum;
            S_INTT: if (bf_en) begin
                c_mem[cnt]    <= addmod(c_mem[cnt], c_v);
                c_mem[hi_idx] <= submod(c_mem[cnt], c_v);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_poly_mult_mac.sv
// Directed bench for poly_mult_mac at the default parameters (Q=17, N=8).
// Expected coefficients are hand-computed products mod (x^8 -/+ 1, 17).
module tb_poly_mult_mac;

    localparam int N    = 8;
    localparam int LOGQ = 5;

    typedef logic [N-1:0][LOGQ-1:0] poly_t;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [LOGQ-1:0] poly_in0;
    logic [LOGQ-1:0] poly_in1;
    logic            acc;
    logic            cyclic;
    logic            in_ready;
    logic            out_valid;
    logic [LOGQ-1:0] poly_out;
    logic            out_ready;
    logic            busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int out_beats = 0;

    poly_mult_mac #(
        .Q(17), .N(8), .LOGQ(5), .LOGN(3), .PSI(3), .PSI_INV(6), .N_INV(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .poly_in0(poly_in0),
        .poly_in1(poly_in1),
        .acc(acc),
        .cyclic(cyclic),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .poly_out(poly_out),
        .out_ready(out_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) out_beats <= out_beats + 1;
    end

    function automatic poly_t pk(input int c0, input int c1, input int c2, input int c3,
                                 input int c4, input int c5, input int c6, input int c7);
        poly_t p;
        p[0] = 5'(c0); p[1] = 5'(c1); p[2] = 5'(c2); p[3] = 5'(c3);
        p[4] = 5'(c4); p[5] = 5'(c5); p[6] = 5'(c6); p[7] = 5'(c7);
        return p;
    endfunction

    task automatic send_pair(input poly_t a, input poly_t b, input logic acc_v,
                             input logic cyc_v, output int e0);
        for (int k = 0; k < N; k++) begin
            int n = 0;
            in_valid = 1'b1;
            poly_in0 = a[k];
            poly_in1 = b[k];
            acc      = acc_v;
            cyclic   = cyc_v;
            while (in_ready !== 1'b1 && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 300) begin
                tests++; fails++;
                $display("FAIL send_beat%0d: in_ready never rose (got %b, want 1)", k, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        e0 = cyc;
    endtask

    task automatic recv_poly(input poly_t exp, input string name, input int e0,
                             input int lat, input int stall_beat);
        for (int k = 0; k < N; k++) begin
            int n = 0;
            while (out_valid !== 1'b1 && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 300) begin
                tests++; fails++;
                $display("FAIL %s_wait%0d: out_valid never rose (got %b, want 1)", name, k, out_valid);
                return;
            end
            if (k == 0 && lat >= 0) begin
                tests++;
                if (cyc - e0 !== lat) begin
                    fails++;
                    $display("FAIL %s_latency: got %0d edges, want %0d", name, cyc - e0, lat);
                end
            end
            if (k == stall_beat) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    tests++;
                    if (poly_out !== exp[k] || out_valid !== 1'b1) begin
                        fails++;
                        $display("FAIL %s_stall%0d: poly_out=%0d valid=%b, want %0d valid=1",
                                 name, s, poly_out, out_valid, exp[k]);
                    end
                end
                out_ready = 1'b1;
            end
            tests++;
            if (poly_out !== exp[k]) begin
                fails++;
                $display("FAIL %s_coef%0d: got %0d, want %0d", name, k, poly_out, exp[k]);
            end
            @(posedge clk); #1;
        end
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_end: out_valid=%b in_ready=%b, want 0 and 1", name, out_valid, in_ready);
        end
    endtask

    // Checks the INIT window after a reset release: in_ready low for 7 edges, high after the 8th.
    task automatic check_init_window(input string name);
        for (int i = 1; i <= N; i++) begin
            @(posedge clk); #1;
            tests++;
            if (in_ready !== (i == N) || busy !== (i != N) || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s_init%0d: in_ready=%b busy=%b out_valid=%b, want %b %b 0",
                         name, i, in_ready, busy, out_valid, i == N, i != N);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || poly_out !== 5'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b poly_out=%0d busy=%b, want 0 0 0 1",
                     in_ready, out_valid, poly_out, busy);
        end
        in_valid = 1'b1;
        reset    = 1'b0;
        check_init_window("reset");
        in_valid = 1'b0;
    endtask

    task automatic test_negacyclic_wrap();
        int e0;
        send_pair(pk(0,1,0,0,0,0,0,0), pk(0,0,0,0,0,0,0,1), 1'b0, 1'b0, e0);
        recv_poly(pk(16,0,0,0,0,0,0,0), "negawrap", e0, -1, -1);
    endtask

    task automatic test_cyclic_wrap();
        int e0;
        send_pair(pk(0,1,0,0,0,0,0,0), pk(0,0,0,0,0,0,0,1), 1'b0, 1'b1, e0);
        recv_poly(pk(1,0,0,0,0,0,0,0), "cycwrap", e0, -1, -1);
    endtask

    task automatic test_identity();
        int e0;
        send_pair(pk(1,0,0,0,0,0,0,0), pk(1,2,3,4,5,6,7,8), 1'b0, 1'b0, e0);
        recv_poly(pk(1,2,3,4,5,6,7,8), "identity", e0, 56, -1);
    endtask

    task automatic test_accumulate();
        int e0;
        int n = 0;
        send_pair(pk(1,0,0,0,0,0,0,0), pk(1,0,0,0,0,0,0,0), 1'b1, 1'b0, e0);
        while (in_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (cyc - e0 !== 32 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL acc_reload: in_ready after %0d edges out_valid=%b, want 32 and 0",
                     cyc - e0, out_valid);
        end
        send_pair(pk(1,0,0,0,0,0,0,0), pk(2,0,0,0,0,0,0,0), 1'b0, 1'b0, e0);
        recv_poly(pk(3,0,0,0,0,0,0,0), "acc_sum", e0, 56, -1);
        send_pair(pk(1,0,0,0,0,0,0,0), pk(1,0,0,0,0,0,0,0), 1'b0, 1'b0, e0);
        recv_poly(pk(1,0,0,0,0,0,0,0), "acc_clear", e0, -1, -1);
    endtask

    task automatic test_back_pressure();
        int e0;
        int beats0;
        send_pair(pk(1,0,0,0,0,0,0,0), pk(1,2,3,4,5,6,7,8), 1'b0, 1'b1, e0);
        beats0 = out_beats;
        recv_poly(pk(1,2,3,4,5,6,7,8), "backpr", e0, -1, 3);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_beats - beats0 !== N) begin
            fails++;
            $display("FAIL backpr_count: got %0d beats, want %0d", out_beats - beats0, N);
        end
    endtask

    task automatic test_mid_reset();
        int e0;
        send_pair(pk(3,1,4,1,5,9,2,6), pk(2,7,1,8,2,8,1,8), 1'b1, 1'b0, e0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_assert: in_ready=%b busy=%b out_valid=%b, want 0 1 0",
                     in_ready, busy, out_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        check_init_window("midrst");
        send_pair(pk(0,1,0,0,0,0,0,0), pk(0,1,0,0,0,0,0,0), 1'b0, 1'b0, e0);
        recv_poly(pk(0,0,1,0,0,0,0,0), "midrst_clean", e0, 56, -1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        poly_in0  = '0;
        poly_in1  = '0;
        acc       = 1'b0;
        cyclic    = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_negacyclic_wrap();
        test_cyclic_wrap();
        test_identity();
        test_accumulate();
        test_back_pressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/poly_mult_mac.md
# poly_mult_mac

Parametrised, streaming NTT-based polynomial multiplier/accumulator over Z_Q[x]/(x^N ± 1). It accepts coefficient pairs over a valid/ready stream, multiplies the two polynomials in the NTT domain, and can accumulate several products before a single inverse NTT. The result streams out over a back-pressured valid/ready port. It generates its own twiddle tables at reset, so it needs no memory-init files. It sits between the coefficient sampler and the lattice-crypto accumulator datapath.

## Interface
- Q, 17: prime modulus; Q ≡ 1 mod 2N.
- N, 8: polynomial length; power of two, 4..256.
- LOGQ, 5: coefficient width, ceil(log2 Q).
- LOGN, 3: log2 N.
- PSI, 3: primitive 2N-th root of unity mod Q.
- PSI_INV, 6: PSI^-1 mod Q.
- N_INV, 15: N^-1 mod Q.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  poly_in0/poly_in1/acc/cyclic are valid.
- poly_in0  in  LOGQ  coefficient of operand A, index order 0..N-1.
- poly_in1  in  LOGQ  coefficient of operand B, same index.
- acc  in  1  sampled on the first beat of a pair; 1 = accumulate only, 0 = accumulate then output.
- cyclic  in  1  sampled on the first beat; 1 = mod x^N−1, 0 = mod x^N+1.
- in_ready  out  1  high only in LOAD.
- out_valid  out  1  high only in OUT.
- poly_out  out  LOGQ  result coefficient, index order 0..N-1.
- out_ready  in  1  consumer accepts poly_out.
- busy  out  1  high in any state other than LOAD.

## Operation
- States: INIT, LOAD, NTT, MAC, INTT, OUT.
- Reset forces INIT, clears CNT, STAGE and the acc_first flag (set to 1), and drives all outputs to 0.
- Reset values: in_ready=0, out_valid=0, poly_out=0, busy=1.
- INIT takes N cycles.
  - Entry k computes w[k]=ω^k with ω=PSI², phi[k]=PSI^k, iphi[k]=N_INV·PSI_INV^k and iw[k]=ω^-k, each by one modular multiply on the previous entry.
  - Then LOAD.
- LOAD: a beat transfers when in_valid && in_ready.
  - Beat k stores A_k·t_k and B_k·t_k at bit-reversed index, where t_k=phi[k] (negacyclic) or 1 (cyclic).
  - acc and cyclic are latched on beat 0 and held for the whole pair.
  - After beat N-1, go to NTT.
- NTT: in-place radix-2 DIT on A and B.
  - LOGN stages × N cycles; one butterfly per cycle where CNT[STAGE]==0, idle otherwise.
  - Then MAC.
- MAC: N cycles.
  - C[bitrev(k)] = (acc_first ? 0 : C[bitrev(k)]) + A[k]·B[k] mod Q.
  - Clear acc_first.
  - If latched acc=1, go to LOAD; else go to INTT.
- INTT: same schedule on C using iw. Then OUT.
- OUT: poly_out = C[CNT]·s mod Q, with s=iphi[CNT] (negacyclic) or N_INV (cyclic).
  - CNT advances only on out_valid && out_ready.
  - After beat N-1, set acc_first=1 and go to LOAD.
- Arithmetic: products are 2·LOGQ bits, reduced by % Q. Add/sub use conditional ±Q so every stored value stays < Q.
- Result equals Σ over accumulated pairs of A·B mod (x^N ∓ 1, Q).
  - The cyclic/negacyclic mode of the final pair governs INTT and output scaling.
  - All pairs in one accumulation must use the same mode; mixing modes is undefined.

## Timing
- in_ready rises N cycles after reset deasserts.
- Let E0 be the edge accepting the last input beat of a pair.
  - acc=0: out_valid rises at edge E0 + 2·LOGN·N + N (E0+56 at defaults).
  - acc=1: in_ready rises at edge E0 + LOGN·N + N (E0+32).
- Input throughput: one beat per cycle while in_valid is held.
- Output stall: while out_valid && !out_ready, poly_out and CNT hold.
- Reset asserted in any state aborts immediately, discards the accumulator and re-runs INIT.
- in_valid outside LOAD is ignored; no beats are lost or double-counted.

## Test plan
- Reset: release reset and drive in_valid=1 → in_ready=0 for 8 cycles, then 1; out_valid=0 throughout.
- Negacyclic wrap: A=x ([0,1,0,0,0,0,0,0]), B=x^7, cyclic=0, acc=0 → poly_out [16,0,0,0,0,0,0,0]. The same pair with cyclic=1 → [1,0,0,0,0,0,0,0].
- Identity: A=[1,0,0,0,0,0,0,0], B=[1,2,3,4,5,6,7,8] → [1,2,3,4,5,6,7,8]; out_valid rises exactly 56 edges after the last input beat.
- Accumulate: pair 1 A=1, B=1, acc=1, then pair 2 A=1, B=2, acc=0 → [3,0,0,0,0,0,0,0]. A following pair A=1, B=1, acc=0 → [1,0,…], proving the accumulator was cleared.
- Back-pressure: hold out_ready=0 for 5 cycles while beat 3 is presented → poly_out stays at coefficient 3 and exactly 8 beats transfer in total.
- Mid-operation reset: pulse reset during NTT of an acc=1 pair → in_ready=0 and busy=1 for 8 cycles. The next A=x, B=x, acc=0 pair gives [0,0,1,0,0,0,0,0] with no residue from the aborted pair.
